// File: rtl/pipeline_ctrl_pkg.sv
// pipeline_ctrl_pkg: state encodings and control-vector constants for the stall/flush sequencer.
package pipeline_ctrl_pkg;
  typedef enum logic [1:0] {
    CTRL_RUN      = 2'd0,
    CTRL_MEM_WAIT = 2'd1,
    CTRL_ERR      = 2'd2
  } ctrl_state_e;
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_stall;
    logic ex_mem_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
    logic pc_redirect;
  } ctrl_t;
  localparam ctrl_t CTRL_NONE     = 8'b0000_0000;
  localparam ctrl_t CTRL_FREEZE   = 8'b1111_0010;
  localparam ctrl_t CTRL_REDIRECT = 8'b0000_1101;
  localparam ctrl_t CTRL_BUBBLE   = 8'b1100_0100;
endpackage

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/bus inputs and stall/flush/redirect controls of the pipeline sequencer.
interface pipeline_ctrl_if;
  logic        load_use_flag;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ack;
  logic        pc_stall;
  logic        if_id_stall;
  logic        id_ex_stall;
  logic        ex_mem_stall;
  logic        if_id_flush;
  logic        id_ex_flush;
  logic        mem_wb_flush;
  logic        pc_redirect;
  logic        bus_err;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  modport master (
    output load_use_flag, ex_branch_taken, mem_req, mem_ack,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    input  if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect,
    input  bus_err, stall_cnt, flush_cnt
  );
  modport slave (
    input  load_use_flag, ex_branch_taken, mem_req, mem_ack,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
    output if_id_flush, id_ex_flush, mem_wb_flush, pc_redirect,
    output bus_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_perf_cnt.sv
// pipe_perf_cnt: wrapping 32-bit stall-cycle and flush-event counters.
// Only built when PIPE_PERF_CNT_EN is defined.
`ifdef PIPE_PERF_CNT_EN
module pipe_perf_cnt (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        stall_i,
  input  logic        flush_i,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);
  logic [31:0] stall_q, stall_d, flush_q, flush_d;
  assign stall_d = stall_q + {31'b0, stall_i};
  assign flush_d = flush_q + {31'b0, flush_i};
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  assign stall_cnt_o = stall_q;
  assign flush_cnt_o = flush_q;
endmodule
`endif

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/redirect sequencer with data-bus watchdog for the 5-stage miniRV pipeline.
// PIPE_PERF_CNT_EN adds the stall/flush performance counters; otherwise they read 0.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic cpu_clk,
  input  logic cpu_rst,
  pipeline_ctrl_if.slave pif
);
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);
  ctrl_state_e state_q, state_d;
  logic [7:0]  wd_q, wd_d;
  ctrl_t       ctl, ctl_o, adv;
  logic        wait_start;
  assign wait_start = pif.mem_req & ~pif.mem_ack;
  // a taken branch squashes the wrong-path load-use request
  assign adv = pif.ex_branch_taken ? CTRL_REDIRECT : pif.load_use_flag ? CTRL_BUBBLE : CTRL_NONE;
  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    ctl     = CTRL_FREEZE;
    case (state_q)
      CTRL_RUN: begin
        ctl     = wait_start ? CTRL_FREEZE : adv;
        state_d = wait_start ? CTRL_MEM_WAIT : CTRL_RUN;
        wd_d    = wait_start ? 8'd1 : 8'd0;
      end
      CTRL_MEM_WAIT: begin
        ctl     = pif.mem_ack ? adv : CTRL_FREEZE;
        state_d = pif.mem_ack ? CTRL_RUN : (wd_q == TIMEOUT) ? CTRL_ERR : CTRL_MEM_WAIT;
        wd_d    = pif.mem_ack ? 8'd0 : wd_q + 8'd1;
      end
      default: state_d = CTRL_ERR;
    endcase
  end
  always_ff @(posedge cpu_clk or posedge cpu_rst)
    if (cpu_rst) begin
      state_q <= CTRL_RUN;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
    end
  assign ctl_o = cpu_rst ? CTRL_NONE : ctl;
  assign {pif.pc_stall, pif.if_id_stall, pif.id_ex_stall, pif.ex_mem_stall,
          pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush, pif.pc_redirect} = ctl_o;
  assign pif.bus_err = ~cpu_rst & (state_q == CTRL_ERR);
`ifdef PIPE_PERF_CNT_EN
  pipe_perf_cnt u_perf (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .stall_i     (ctl_o.pc_stall),
    .flush_i     (ctl_o.if_id_flush | ctl_o.id_ex_flush),
    .stall_cnt_o (pif.stall_cnt),
    .flush_cnt_o (pif.flush_cnt)
  );
`else
  assign pif.stall_cnt = '0;
  assign pif.flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb_pipeline_ctrl: table, hand-written and random checks of pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;
  localparam int TO = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] FRZ   = 9'b111100100;
  localparam logic [8:0] ERRV  = 9'b111100101;
  localparam logic [8:0] REDIR = 9'b000011010;
  localparam logic [8:0] BUB   = 9'b110001000;
  logic cpu_clk = 1'b0;
  logic cpu_rst = 1'b1;
  pipeline_ctrl_if pif();
  pipeline_ctrl #(.MEM_TIMEOUT(TO)) dut (.cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .pif(pif));
  always #5 cpu_clk = ~cpu_clk;
  int checks = 0;
  int errors = 0;
  bit m_wait, m_hung;
  int m_waited;
  logic [31:0] m_stall, m_flush;
  typedef struct {
    logic lu, br, req, ack;
    logic [8:0] want;
    string name;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [8:0] dut_vec();
    return {pif.pc_stall, pif.if_id_stall, pif.id_ex_stall, pif.ex_mem_stall,
            pif.if_id_flush, pif.id_ex_flush, pif.mem_wb_flush, pif.pc_redirect, pif.bus_err};
  endfunction

  function automatic logic [8:0] model_out(input logic lu, br, req, ack);
    if (m_hung) return ERRV;
    if ((m_wait || req) && !ack) return FRZ;
    if (br) return REDIR;
    if (lu) return BUB;
    return NONE;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic cyc(input logic lu, br, req, ack, input logic [8:0] want, input bit use_want,
                     input string name);
    logic [8:0] e;
    @(negedge cpu_clk);
    pif.load_use_flag = lu; pif.ex_branch_taken = br; pif.mem_req = req; pif.mem_ack = ack;
    #1;
    e = model_out(lu, br, req, ack);
    check(name, {23'b0, dut_vec()}, {23'b0, use_want ? want : e});
    m_stall += {31'b0, e[8]};
    m_flush += {31'b0, e[4] | e[3]};
    if (!m_hung) begin
      if ((m_wait || req) && !ack) begin
        if (!m_wait) begin m_wait = 1; m_waited = 1; end
        else if (m_waited == TO) m_hung = 1;
        else m_waited++;
      end else if (ack) m_wait = 0;
    end
    @(posedge cpu_clk);
    #1;
    check({name, "_scnt"}, pif.stall_cnt, PERF ? m_stall : 32'd0);
    check({name, "_fcnt"}, pif.flush_cnt, PERF ? m_flush : 32'd0);
  endtask

  task automatic do_reset();
    @(negedge cpu_clk);
    pif.load_use_flag = 1; pif.ex_branch_taken = 0; pif.mem_req = 1; pif.mem_ack = 0;
    #2 cpu_rst = 1;
    #1;
    check("rst_ctl", {23'b0, dut_vec()}, 32'd0);
    check("rst_scnt", pif.stall_cnt, 32'd0);
    check("rst_fcnt", pif.flush_cnt, 32'd0);
    m_wait = 0; m_hung = 0; m_waited = 0; m_stall = 0; m_flush = 0;
    @(negedge cpu_clk);
    pif.load_use_flag = 0; pif.mem_req = 0;
    cpu_rst = 0;
  endtask

  initial begin
    logic [31:0] s0;
    pif.load_use_flag = 0; pif.ex_branch_taken = 0; pif.mem_req = 0; pif.mem_ack = 0;
    tbl[0] = '{0, 0, 0, 0, NONE,  "idle"};
    tbl[1] = '{1, 0, 0, 0, BUB,   "lu"};
    tbl[2] = '{0, 1, 0, 0, REDIR, "br"};
    tbl[3] = '{1, 1, 0, 0, REDIR, "br_lu"};
    tbl[4] = '{0, 0, 1, 1, NONE,  "zero_wait"};
    tbl[5] = '{1, 0, 1, 1, BUB,   "zw_lu"};
    tbl[6] = '{1, 1, 1, 1, REDIR, "zw_br"};
    tbl[7] = '{0, 0, 0, 1, NONE,  "ack_noreq"};
    do_reset();
    for (int i = 0; i < 8; i++) cyc(tbl[i].lu, tbl[i].br, tbl[i].req, tbl[i].ack, tbl[i].want, 1, tbl[i].name);
    do_reset();
    cyc(1, 0, 0, 0, BUB, 1, "lu_once");
    cyc(0, 0, 0, 0, NONE, 1, "lu_after");
    s0 = pif.stall_cnt;
    cyc(0, 0, 1, 0, FRZ, 1, "mw_run");
    cyc(1, 1, 1, 0, FRZ, 1, "mw_ignore");
    cyc(0, 0, 1, 0, FRZ, 1, "mw_w2");
    cyc(0, 0, 1, 1, NONE, 1, "mw_ack");
    cyc(0, 0, 0, 0, NONE, 1, "mw_after");
    check("mw_stalls", pif.stall_cnt - s0, PERF ? 32'd3 : 32'd0);
    cyc(0, 0, 1, 0, FRZ, 1, "mwb_run");
    cyc(0, 1, 1, 1, REDIR, 1, "mwb_ack_br");
    cyc(0, 0, 1, 0, FRZ, 1, "mwl_run");
    cyc(1, 0, 1, 1, BUB, 1, "mwl_ack_lu");
    cyc(0, 0, 1, 0, FRZ, 1, "wda_run");
    for (int i = 1; i < TO; i++) cyc(0, 0, 1, 0, FRZ, 1, "wda_wait");
    cyc(0, 0, 1, 1, NONE, 1, "wda_ack_wins");
    cyc(1, 0, 0, 0, BUB, 1, "wda_run_again");
    cyc(0, 0, 1, 0, FRZ, 1, "wd_run");
    for (int i = 1; i <= TO; i++) cyc(0, 0, 1, 0, FRZ, 1, "wd_wait");
    cyc(0, 0, 1, 1, ERRV, 1, "wd_err");
    cyc(1, 1, 0, 0, ERRV, 1, "wd_err_hold");
    do_reset();
    cyc(0, 1, 0, 0, REDIR, 1, "post_rst_br");
`ifdef PIPE_PERF_CNT_EN
    @(negedge cpu_clk);
    force dut.u_perf.stall_q = 32'hFFFF_FFFF;
    #1 release dut.u_perf.stall_q;
    m_stall = 32'hFFFF_FFFF;
    cyc(1, 0, 0, 0, BUB, 1, "wrap");
    check("wrap_zero", pif.stall_cnt, 32'd0);
`endif
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 97 == 96) do_reset();
      cyc(($urandom % 4) == 0, ($urandom % 5) == 0, ($urandom % 3) == 0, ($urandom % 2) == 0,
          NONE, 0, "rnd");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Stall/flush sequencer for the 5-stage miniRV pipeline. It combines the load-use flag from the data-hazard forwarding unit, taken-branch/jump resolution from EX, and the wait handshake of the data-memory bus. From these it generates per-stage stall, flush and PC-redirect controls. A watchdog detects a hung bus access and parks the core in an error state.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum MEM_WAIT cycles before error (1..255, 8-bit counter)

Ports:
- cpu_clk  in  1  core clock
- cpu_rst  in  1  asynchronous reset, active-high
- load_use_flag  in  1  load in EX feeds rs1/rs2 of instruction in ID (from hazard unit)
- ex_branch_taken  in  1  branch/jal/jalr in EX redirects PC
- mem_req  in  1  instruction in MEM accesses the data bus
- mem_ack  in  1  data bus completes access this cycle
- pc_stall  out  1  hold PC
- if_id_stall  out  1  hold IF/ID register
- id_ex_stall  out  1  hold ID/EX register
- ex_mem_stall  out  1  hold EX/MEM register
- if_id_flush  out  1  load bubble into IF/ID
- id_ex_flush  out  1  load bubble into ID/EX
- mem_wb_flush  out  1  load bubble into MEM/WB
- pc_redirect  out  1  PC takes EX branch target
- bus_err  out  1  watchdog expired; sticky until reset
- stall_cnt  out  32  stall cycles (PERF_CNT_EN)
- flush_cnt  out  32  flush events (PERF_CNT_EN)

## Operation
- States: RUN, MEM_WAIT, ERR. Encoded 2 bits.
- Controls are Mealy outputs of state and inputs; state, watchdog and counters are registered.
- RUN priority, highest first:
  - mem_req & !mem_ack: assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush. Go to MEM_WAIT; watchdog loads 1.
  - ex_branch_taken: assert pc_redirect, if_id_flush, id_ex_flush. Any load-use in the same cycle is ignored because it is on the wrong path.
  - load_use_flag: assert pc_stall, if_id_stall, id_ex_flush. This inserts exactly one bubble. The load then sits in MEM and the hazard unit forwards its read data.
  - Otherwise all controls are 0.
- mem_req & mem_ack in the same RUN cycle is a zero-wait access: no stall, no state change.
- MEM_WAIT:
  - While !mem_ack: all four stalls plus mem_wb_flush are asserted. branch and load-use are ignored because EX/ID are frozen. Watchdog increments.
  - On mem_ack: the pipeline advances. Outputs equal the RUN decode excluding the mem term (branch or load-use may fire this cycle). Next state is RUN.
  - Watchdog == MEM_TIMEOUT and !mem_ack: go to ERR. mem_ack in the same cycle wins (go to RUN).
- ERR: all four stalls and mem_wb_flush asserted, bus_err=1. Exit only by reset.
- Counters:
  - stall_cnt +1 every cycle pc_stall=1.
  - flush_cnt +1 every cycle if_id_flush|id_ex_flush=1.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Reset asserted, asynchronously: state RUN, watchdog 0, counters 0. All control outputs are forced 0, bus_err 0.
- Reset deasserted mid MEM_WAIT or ERR: restart in RUN. The bus is re-arbitrated externally.
- Latency:
  - stall/flush/redirect are combinational, same cycle as cause.
  - State takes effect next cpu_clk rising edge.
- Load-use costs 1 cycle; taken branch costs 2 flushed slots.
- A memory access with N wait cycles costs N stall cycles.
- ERR is entered MEM_TIMEOUT cycles after the first wait cycle.

## Configuration
- PIPE_PERF_CNT_EN defined: stall_cnt/flush_cnt implemented as above.
- Undefined: counters removed; stall_cnt and flush_cnt tied to 32'b0. Control behaviour is identical.

## Structure
- State encodings go in defines.vh alongside the existing WB_* selects: CTRL_RUN=2'd0, CTRL_MEM_WAIT=2'd1, CTRL_ERR=2'd2.
- One sub-module, pipe_perf_cnt, holds the two 32-bit wrapping counters. It is instantiated only under PIPE_PERF_CNT_EN.

## Test plan
- Load-use: load_use_flag=1 for one RUN cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_cnt=1, flush_cnt=1.
- Branch vs load-use: ex_branch_taken=1 and load_use_flag=1 together -> pc_redirect=if_id_flush=id_ex_flush=1, pc_stall=0.
- Memory wait: mem_req=1, mem_ack low 3 cycles then high -> 3 cycles of full stall plus mem_wb_flush; ack cycle has all controls 0; state RUN after; stall_cnt=3.
- Zero-wait access: mem_req=mem_ack=1 -> no stall, state stays RUN.
- Watchdog: MEM_TIMEOUT=4, mem_ack never -> ERR after 4 wait cycles, bus_err=1 held. Asserting cpu_rst mid-cycle clears it immediately.
- Counter wrap (PIPE_PERF_CNT_EN): force stall_cnt=0xFFFFFFFF, one load-use stall -> stall_cnt=0. Without the macro both counters read 0 throughout.
